// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 size codes, FSM states and size helpers.
package dmem_responder_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // ST_LAND is the cycle in which the registered RAM read of the last word is visible.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC0 = 3'd1,
    ST_ACC1 = 3'd2,
    ST_LAND = 3'd3,
    ST_ERR  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Returns 0 for size codes that have no defined width.
  function automatic logic [2:0] size_nbytes(input logic [2:0] size);
    case (size)
      MEM_B, MEM_BU: return 3'd1;
      MEM_H, MEM_HU: return 3'd2;
      MEM_W:         return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [31:0] raw);
    case (size)
      MEM_B:   return {{24{raw[7]}}, raw[7:0]};
      MEM_BU:  return {24'h0, raw[7:0]};
      MEM_H:   return {{16{raw[15]}}, raw[15:0]};
      MEM_HU:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port DEPTH x 32 data RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge clk) begin
    rdata_q <= mem[addr];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder: one sized, possibly word-crossing access at a time
// against a private word RAM, answered over a valid/ready response channel.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  state_e          state_q, state_d;
  logic [AW-1:0]   word_q, word_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      size_q, size_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            cross_q, cross_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     offset;
  logic [2:0]      nbytes;
  logic [32:0]     last_byte;
  logic            req_illegal;
  logic            req_cross;

  logic [3:0]      lane_mask;
  logic [7:0]      be8;
  logic [63:0]     wdata64;
  logic [63:0]     raw64;
  logic [31:0]     aligned32;

  logic [AW-1:0]   ram_addr;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Request decode; the range checks use 33 bits so the last-byte sum cannot wrap.
  always_comb begin
    offset      = req_addr - BASE_ADDR;
    nbytes      = size_nbytes(req_size);
    last_byte   = {1'b0, offset} + {30'h0, nbytes} - 33'd1;
    req_cross   = ({1'b0, offset[1:0]} + nbytes) > 3'd4;
    req_illegal = (nbytes == 3'd0)
               || (req_we && (req_size == MEM_BU || req_size == MEM_HU))
               || ({1'b0, offset} >= SPAN)
               || (last_byte >= SPAN);
  end

  // Lane steering shared by the store and load paths.
  always_comb begin
    case (size_q)
      MEM_B, MEM_BU: lane_mask = 4'b0001;
      MEM_H, MEM_HU: lane_mask = 4'b0011;
      default:       lane_mask = 4'b1111;
    endcase
    be8       = {4'b0000, lane_mask} << lane_q;
    wdata64   = {32'h0, wdata_q} << {lane_q, 3'b000};
    raw64     = cross_q ? {ram_rdata, lo_q} : {32'h0, ram_rdata};
    aligned32 = 32'(raw64 >> {lane_q, 3'b000});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cross_q <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cross_q <= cross_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lane_d  = lane_q;
    size_d  = size_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cross_d = cross_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          word_d  = offset[AW+1:2];
          lane_d  = offset[1:0];
          size_d  = req_size;
          we_d    = req_we;
          wdata_d = req_wdata;
          cross_d = req_cross;
          state_d = req_illegal ? ST_ERR : ST_ACC0;
        end
      end
      ST_ACC0: state_d = cross_q ? ST_ACC1 : ST_LAND;
      ST_ACC1: begin
        lo_d    = ram_rdata;
        state_d = ST_LAND;
      end
      ST_LAND: begin
        rdata_d = we_q ? 32'h0 : load_extend(size_q, aligned32);
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_ERR: begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ACC0 touches the addressed word, ACC1 the following one.
  always_comb begin
    req_ready = (state_q == ST_IDLE) && rst_n;
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    ram_addr  = word_q;
    ram_wdata = wdata64[31:0];
    ram_be    = 4'b0000;
    if (state_q == ST_ACC1) begin
      ram_addr  = word_q + AW'(1);
      ram_wdata = wdata64[63:32];
      if (we_q) ram_be = be8[7:4];
    end else if (state_q == ST_ACC0 && we_q) begin
      ram_be = be8[3:0];
    end
  end

endmodule
